// File: rtl/serial_subtractor_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package sub_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_subtractor_if.sv
// Launch/collect handshake bundle between a controller and serial_subtractor.
interface serial_subtractor_if
  import sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             b_out;
  logic             overflow;

  modport master (
    output start, a, b,
    input  ready, done, diff, b_out, overflow
  );

  modport slave (
    input  start, a, b,
    output ready, done, diff, b_out, overflow
  );

endinterface

// File: rtl/serial_subtractor_one_bit_sub.sv
// Combinational one-bit full subtractor: d = x - y - b_in, with borrow out.
module one_bit_sub (
  input  logic x,
  input  logic y,
  input  logic b_in,
  output logic d,
  output logic b_out
);

  assign d     = x ^ y ^ b_in;
  assign b_out = (~x & y) | (~x & b_in) | (y & b_in);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, one bit per clock through a single full-subtractor cell.
module serial_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_subtractor_if.slave  bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic [CW-1:0]    r_cnt;
  logic             r_borrow;
  logic             r_a_msb;
  logic             r_b_msb;
  logic             r_ready;
  logic             r_done;
  logic [WIDTH-1:0] r_diff;
  logic             r_b_out;
  logic             r_ovf;

  logic             w_d;
  logic             w_bout;
  logic [WIDTH-1:0] w_res_next;

  one_bit_sub u_cell (
    .x    (r_a[0]),
    .y    (r_b[0]),
    .b_in (r_borrow),
    .d    (w_d),
    .b_out(w_bout)
  );

  // Result fills from the top so that after WIDTH shifts bit 0 holds the LSB.
  assign w_res_next = {w_d, r_res[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_res    <= '0;
      r_cnt    <= '0;
      r_borrow <= 1'b0;
      r_a_msb  <= 1'b0;
      r_b_msb  <= 1'b0;
      r_ready  <= 1'b1;
      r_done   <= 1'b0;
      r_diff   <= '0;
      r_b_out  <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_a      <= bus.a;
            r_b      <= bus.b;
            r_res    <= '0;
            r_cnt    <= '0;
            r_borrow <= 1'b0;
            r_a_msb  <= bus.a[WIDTH-1];
            r_b_msb  <= bus.b[WIDTH-1];
            r_ready  <= 1'b0;
            r_state  <= RUN;
          end
        end
        RUN: begin
          r_a      <= {1'b0, r_a[WIDTH-1:1]};
          r_b      <= {1'b0, r_b[WIDTH-1:1]};
          r_res    <= w_res_next;
          r_borrow <= w_bout;
          if (r_cnt == LAST_BIT) begin
            // Outputs load from the final-bit values so they are valid on DONE entry.
            r_diff  <= w_res_next;
            r_b_out <= w_bout;
            r_ovf   <= (r_a_msb ^ r_b_msb) & (w_d ^ r_a_msb);
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.ready    = r_ready;
  assign bus.done     = r_done;
  assign bus.diff     = r_diff;
  assign bus.b_out    = r_b_out;
  assign bus.overflow = r_ovf;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random checks of serial_subtractor (WIDTH=8).
module tb_serial_subtractor;

  localparam int W = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Launch one operation from a negedge with ready=1 and check result and latency.
  task automatic do_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                       input logic [7:0] exp_d, input logic exp_bo, input logic exp_ov,
                       input bit full);
    int cycles;
    int ready_low;
    @(negedge clk);
    if (full) check({tag, "_ready_before"}, 32'(bus.ready), 32'd1);
    bus.a     = av;
    bus.b     = bv;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = 8'h00;
    bus.b     = 8'h00;
    cycles    = 1;
    ready_low = bus.ready ? 0 : 1;
    while (!bus.done && cycles < 40) begin
      @(negedge clk);
      cycles++;
      if (!bus.ready) ready_low++;
    end
    check({tag, "_diff"}, 32'(bus.diff), 32'(exp_d));
    check({tag, "_b_out"}, 32'(bus.b_out), 32'(exp_bo));
    check({tag, "_ovf"}, 32'(bus.overflow), 32'(exp_ov));
    if (full) begin
      check({tag, "_latency"}, 32'(cycles), 32'd9);
      check({tag, "_ready_low"}, 32'(ready_low), 32'd9);
      @(negedge clk);
      check({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
      check({tag, "_ready_after"}, 32'(bus.ready), 32'd1);
    end else begin
      @(negedge clk);
    end
  endtask

  initial begin
    int cnt;
    int done_cnt;
    logic [7:0] cap_d;
    logic cap_bo;
    logic cap_ov;
    logic [7:0] ra;
    logic [7:0] rb;
    logic [7:0] rd;

    bus.start = 1'b0;
    bus.a     = 8'h00;
    bus.b     = 8'h00;

    // Reset state
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("rst_ready", 32'(bus.ready), 32'd1);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_diff", 32'(bus.diff), 32'd0);
    check("rst_flags", {30'd0, bus.b_out, bus.overflow}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    $display("reset checks done");

    do_op("t05m03", 8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 1'b1);
    $display("op 05-03 -> diff=%02h b_out=%0d ovf=%0d", bus.diff, bus.b_out, bus.overflow);
    do_op("t03m05", 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, 1'b1);
    $display("op 03-05 -> diff=%02h b_out=%0d ovf=%0d", bus.diff, bus.b_out, bus.overflow);
    do_op("t80m01", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b1);
    $display("op 80-01 -> diff=%02h b_out=%0d ovf=%0d", bus.diff, bus.b_out, bus.overflow);
    do_op("t7Fm7F", 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1, 1'b1);
    $display("op 7F-FF -> diff=%02h b_out=%0d ovf=%0d", bus.diff, bus.b_out, bus.overflow);

    // Back-to-back with start held high: 00-00 then FF-01
    @(negedge clk);
    bus.a     = 8'h00;
    bus.b     = 8'h00;
    bus.start = 1'b1;
    @(negedge clk);
    bus.a = 8'hFF;
    bus.b = 8'h01;
    cnt = 1;
    while (!bus.done && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    check("held1_latency", 32'(cnt), 32'd9);
    check("held1_diff", 32'(bus.diff), 32'h00);
    check("held1_flags", {30'd0, bus.b_out, bus.overflow}, 32'd0);
    $display("op 00-00 (held) -> diff=%02h", bus.diff);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!bus.done && cnt < 40);
    bus.start = 1'b0;
    check("held2_spacing", 32'(cnt), 32'd10);
    check("held2_diff", 32'(bus.diff), 32'hFE);
    check("held2_flags", {30'd0, bus.b_out, bus.overflow}, 32'd0);
    $display("op FF-01 (held) -> diff=%02h spacing=%0d", bus.diff, cnt);
    @(negedge clk);

    // Start pulsed mid-RUN must be ignored: 9C-31 = 6B, overflow set
    @(negedge clk);
    bus.a     = 8'h9C;
    bus.b     = 8'h31;
    bus.start = 1'b1;
    done_cnt  = 0;
    cap_d     = 8'h00;
    cap_bo    = 1'b0;
    cap_ov    = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      bus.start = (i == 3);
      if (i == 3) begin
        bus.a = 8'h11;
        bus.b = 8'h22;
      end
      if (bus.done) begin
        done_cnt++;
        cap_d  = bus.diff;
        cap_bo = bus.b_out;
        cap_ov = bus.overflow;
      end
    end
    bus.start = 1'b0;
    check("ign_done_count", 32'(done_cnt), 32'd1);
    check("ign_diff", 32'(cap_d), 32'h6B);
    check("ign_b_out", 32'(cap_bo), 32'd0);
    check("ign_ovf", 32'(cap_ov), 32'd1);
    $display("op 9C-31 with stray start -> diff=%02h dones=%0d", cap_d, done_cnt);

    // Reset during RUN aborts and clears outputs
    @(negedge clk);
    bus.a     = 8'h40;
    bus.b     = 8'h10;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_ready", 32'(bus.ready), 32'd1);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_diff", 32'(bus.diff), 32'd0);
    check("abort_flags", {30'd0, bus.b_out, bus.overflow}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bus.done) done_cnt++;
    end
    check("abort_no_done", 32'(done_cnt), 32'd0);
    $display("reset mid-RUN -> dones after abort=%0d", done_cnt);

    do_op("post_rst", 8'h10, 8'h20, 8'hF0, 1'b1, 1'b0, 1'b1);
    $display("op 10-20 after reset -> diff=%02h b_out=%0d", bus.diff, bus.b_out);

    // Random pairs against an arithmetic reference
    for (int k = 0; k < 1000; k++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rd = ra - rb;
      do_op("rand", ra, rb, rd, (ra < rb), (ra[7] != rb[7]) && (rd[7] != ra[7]), 1'b0);
    end
    $display("random: 1000 operations checked");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial N-bit subtractor computing `a - b`, one bit per clock, LSB first, through a single one-bit full-subtractor cell. Datapath-side companion to the one-bit full-adder cell: adder computes sum/carry, this block computes difference/borrow. A start/ready/done handshake lets a controller or FSM launch it and collect the result. Outputs include the unsigned borrow and the signed overflow flags.

## Interface
- `WIDTH`, default 8: operand and result width in bits. Must be ≥ 2.
- `clk` input 1: single clock; all state changes on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: launch request. Sampled only when `ready`=1.
- `a` input WIDTH: minuend. Captured on the accepted `start` edge.
- `b` input WIDTH: subtrahend. Captured on the accepted `start` edge.
- `ready` output 1: 1 in IDLE only.
- `done` output 1: one-cycle pulse; result valid.
- `diff` output WIDTH: `(a - b) mod 2^WIDTH`.
- `b_out` output 1: final borrow. 1 iff a < b unsigned.
- `overflow` output 1: two's-complement overflow of `a - b`.

## Operation
- States: IDLE → RUN → DONE → IDLE.
- IDLE:
  - `ready`=1.
  - On `start`=1: load shift registers with a and b, clear the borrow flop, clear the bit counter, latch `a[WIDTH-1]` and `b[WIDTH-1]` for overflow, go to RUN.
- RUN, each cycle:
  - Cell inputs: x = LSB of the a-register, y = LSB of the b-register, bin = borrow flop.
  - Cell outputs: d = x^y^bin; bout = ~x&y | ~x&bin | y&bin.
  - Shift d into the MSB of the result register (right shift). Shift both operand registers right. Borrow flop ← bout. Counter +1.
  - When the counter reaches WIDTH-1, this is the last bit: go to DONE.
- DONE (one cycle):
  - `done`=1.
  - Output registers update on entry: `diff` = result register; `b_out` = borrow flop; `overflow` = (a_msb ≠ b_msb) & (diff[WIDTH-1] ≠ a_msb).
  - Next state is IDLE.
- `diff`, `b_out` and `overflow` hold their value until the next DONE entry. They do not change during IDLE or RUN.
- `start` outside IDLE is ignored, not queued.
- `a` and `b` are don't-care after the accepted edge.

## Timing
- Reset (async assert, sync release) drives:
  - state IDLE, `ready`=1, `done`=0;
  - `diff`=0, `b_out`=0, `overflow`=0;
  - counter, borrow flop and all shift registers to 0.
- Reset mid-RUN or mid-DONE aborts the operation. No `done` pulse follows.
- Latency, with `start` accepted on edge 0:
  - RUN occupies edges 1..WIDTH.
  - `done`=1 and result valid in the cycle after edge WIDTH. For WIDTH=8 that is 9 cycles from start to done.
  - `ready` returns to 1 the following cycle.
- Throughput: one operation per WIDTH+2 cycles. With `start` held high, a new operation begins the first cycle `ready`=1.
- `ready`=0 throughout RUN and DONE.
- Counter width is clog2(WIDTH). Counter wrap is never reached, because the exit happens at WIDTH-1.

## Structure
- Shared package `sub_pkg`:
  - FSM state enum (IDLE, RUN, DONE), 2-bit encoding;
  - default WIDTH constant.
- One sub-module, `one_bit_sub`: purely combinational full subtractor, ports x, y, b_in, d, b_out. Instantiated once in the datapath.
- Top level holds the FSM, counter, two operand shift registers, result shift register, borrow flop, MSB latches and output registers.

## Test plan
- WIDTH=8, a=0x05, b=0x03, pulse start → `done` 9 cycles later; `diff`=0x02, `b_out`=0, `overflow`=0; `ready` low for exactly 9 cycles.
- a=0x03, b=0x05 → `diff`=0xFE, `b_out`=1, `overflow`=0.
- a=0x80, b=0x01 → `diff`=0x7F, `b_out`=0, `overflow`=1. Also a=0x7F, b=0xFF → `diff`=0x80, `b_out`=1, `overflow`=1.
- a=0x00, b=0x00 → `diff`=0x00, flags 0. Then, with `start` held high, a=0xFF, b=0x01 → second `done` exactly 10 cycles after the first, `diff`=0xFE.
- `start` pulsed again at cycle 3 of RUN with different operands → ignored; result matches the first operands; only one `done` pulse.
- `rst_n` asserted at cycle 4 of RUN → immediately `ready`=1, outputs all 0, no `done`. A new start after release gives a correct result. Randomized check: 1000 random pairs against a reference model.
